fc_batch_ctrl: RTL

Parametrised batch sequencer between the shared 32-bit data BRAM and one fully-connected layer. On `start` it runs `batch_cnt` batches. For each batch it:
- streams DIM_INPUT packed input elements from the load region into the FC core;
- waits for the core's result vector;
- packs the DIM_OUTPUT results into lanes and writes them to the store region.

Completion is signalled to the host by `done`, and a `result_ready` level is held until the host acknowledges.

---
 rtl/fc_ctrl_pkg.sv | 31 +++
 rtl/fc_in_unpacker.sv | 105 ++++++++++
 rtl/fc_batch_ctrl.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fc_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------+
// | fc_ctrl_pkg                                                     |
// | Shared state encoding and lane-extension helper.                |
// | Rev 1.0                                                         |
// +----------------------------------------------------------------+
package fc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_STORE = 3'd3,
        ST_DONE  = 3'd4
    } fc_state_t;

    // Extends the low `width` bits of val to 64 bits; callers truncate to their lane.
    function automatic logic [63:0] sext_lane(input logic [63:0] val,
                                              input int unsigned width,
                                              input logic        sign_ext);
        logic [63:0] r;
        logic        msb;
        msb = sign_ext & val[6'(width - 1)];
        for (int i = 0; i < 64; i++) begin
            r[i] = (unsigned'(i) < width) ? val[i] : msb;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fc_in_unpacker.sv
`default_nettype none
// +----------------------------------------------------------------+
// | fc_in_unpacker                                                  |
// | Splits BRAM words into a gap-free stream of FC input elements.  |
// | Rev 1.0                                                         |
// +----------------------------------------------------------------+
module fc_in_unpacker #(
    parameter int INPUT_W   = 16,
    parameter int WORD_W    = 32,
    parameter int DIM_INPUT = 96
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush_i,
    input  logic               load_i,
    input  logic [WORD_W-1:0]  word_i,
    output logic               vld_o,
    output logic [INPUT_W-1:0] dat_o,
    output logic               last_o
);
    localparam int IPW = WORD_W / INPUT_W;
    localparam int IW  = (IPW > 1) ? $clog2(IPW) : 1;
    localparam int BW  = (DIM_INPUT > 1) ? $clog2(DIM_INPUT) : 1;

    logic [WORD_W-1:0]  word_q, word_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic               act_q, act_d;
    logic [BW-1:0]      beat_q, beat_d;
    logic               vld_q, vld_d;
    logic               last_q, last_d;
    logic [INPUT_W-1:0] dat_q, dat_d;
    logic [INPUT_W-1:0] w_sel;
    logic               w_emit;

    always_comb begin
        w_sel = word_q[INPUT_W-1:0];
        for (int k = 0; k < IPW; k++) begin
            if (idx_q == IW'(k)) w_sel = word_q[k*INPUT_W +: INPUT_W];
        end
    end

    always_comb begin
        word_d = word_q;
        idx_d  = idx_q;
        act_d  = act_q;
        beat_d = beat_q;
        dat_d  = dat_q;
        vld_d  = 1'b0;
        last_d = 1'b0;
        w_emit = 1'b0;
        if (flush_i) begin
            act_d  = 1'b0;
            idx_d  = '0;
            beat_d = '0;
        end else if (load_i) begin
            // Element 0 goes straight out so the next word lands exactly as this one drains.
            word_d = word_i;
            dat_d  = word_i[INPUT_W-1:0];
            w_emit = 1'b1;
            idx_d  = '0;
            if (IPW > 1) idx_d = IW'(1);
            act_d  = (IPW > 1);
        end else if (act_q) begin
            dat_d  = w_sel;
            w_emit = 1'b1;
            if (idx_q == IW'(IPW - 1)) begin
                act_d = 1'b0;
                idx_d = '0;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
        if (w_emit) begin
            vld_d  = 1'b1;
            last_d = (beat_q == BW'(DIM_INPUT - 1));
            beat_d = last_d ? '0 : beat_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            word_q <= '0;
            idx_q  <= '0;
            act_q  <= 1'b0;
            beat_q <= '0;
            dat_q  <= '0;
            vld_q  <= 1'b0;
            last_q <= 1'b0;
        end else begin
            word_q <= word_d;
            idx_q  <= idx_d;
            act_q  <= act_d;
            beat_q <= beat_d;
            dat_q  <= dat_d;
            vld_q  <= vld_d;
            last_q <= last_d;
        end
    end

    assign vld_o  = vld_q;
    assign dat_o  = dat_q;
    assign last_o = last_q;

endmodule
`default_nettype wire

// File: rtl/fc_batch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------+
// | fc_batch_ctrl                                                   |
// | Batch sequencer between the data BRAM and one FC layer core.    |
// | Rev 1.0                                                         |
// +----------------------------------------------------------------+
module fc_batch_ctrl
    import fc_ctrl_pkg::*;
#(
    parameter int              DIM_INPUT  = 96,
    parameter int              DIM_OUTPUT = 8,
    parameter int              INPUT_W    = 16,
    parameter int              OUTPUT_W   = 8,
    parameter int              LANE_W     = 16,
    parameter int              SIGN_EXT   = 0,
    parameter int              WORD_W     = 32,
    parameter int              ADDR_W     = 12,
    parameter logic [ADDR_W-1:0] LOAD_BASE  = 'h000,
    parameter logic [ADDR_W-1:0] STORE_BASE = 'hD00,
    parameter int              MAX_BATCH  = 16,
    localparam int             BCW        = $clog2(MAX_BATCH + 1)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [BCW-1:0]                 batch_cnt,
    input  logic                           abort,
    input  logic                           rd_ack,
    output logic                           busy,
    output logic                           done,
    output logic                           result_ready,
    output logic                           err,
    output logic                           fc_in_vld,
    output logic [INPUT_W-1:0]             fc_in_dat,
    output logic                           fc_in_last,
    input  logic                           fc_out_vld,
    input  logic [DIM_OUTPUT*OUTPUT_W-1:0] fc_out_dat,
    output logic                           mem_en,
    output logic                           mem_we,
    output logic [ADDR_W-1:0]              mem_addr,
    output logic [WORD_W-1:0]              mem_din,
    input  logic [WORD_W-1:0]              mem_dout
);
    localparam int IPW     = WORD_W / INPUT_W;
    localparam int OPW     = WORD_W / LANE_W;
    localparam int WPB_IN  = DIM_INPUT / IPW;
    localparam int WPB_OUT = DIM_OUTPUT / OPW;
    localparam int PW      = (IPW > 1) ? $clog2(IPW) : 1;
    localparam int RLW     = $clog2(WPB_IN + 1);
    localparam int WCW     = $clog2(WPB_OUT + 1);
    localparam int VW      = DIM_OUTPUT * OUTPUT_W;

    if ((WORD_W % INPUT_W) != 0 || (WORD_W % LANE_W) != 0 || (DIM_INPUT % IPW) != 0 ||
        (DIM_OUTPUT % OPW) != 0 || LANE_W < OUTPUT_W || OUTPUT_W > 64) begin : g_param_check
        $error("fc_batch_ctrl: inconsistent width/dimension parameters");
    end

    fc_state_t         state_q, state_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [RLW-1:0]    rd_left_q, rd_left_d;
    logic [PW-1:0]     ph_q, ph_d;
    logic              rd_pend_q, rd_pend_d;
    logic [BCW-1:0]    b_q, b_d, bcnt_q, bcnt_d;
    logic [WCW-1:0]    wr_cnt_q, wr_cnt_d;
    logic [VW-1:0]     cap_q, cap_d;
    logic              busy_q, busy_d, done_q, done_d, rr_q, rr_d, err_q, err_d;
    logic              mem_en_q, mem_en_d, mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [WORD_W-1:0] mem_din_q, mem_din_d;

    logic              w_abort, w_err_set, w_rd_first, w_rd_go, w_wr_go;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [VW-1:0]     w_store_vec;
    logic [WORD_W-1:0] w_pack_word;

    // Word 0 is written on the capture edge, so it packs straight from the core bus.
    always_comb begin
        w_store_vec = (state_q == ST_WAIT) ? fc_out_dat : cap_q;
        w_pack_word = '0;
        for (int j = 0; j < WPB_OUT; j++) begin
            if (wr_cnt_q == WCW'(j)) begin
                for (int k = 0; k < OPW; k++) begin
                    w_pack_word[k*LANE_W +: LANE_W] = LANE_W'(sext_lane(
                        64'(w_store_vec[(j*OPW+k)*OUTPUT_W +: OUTPUT_W]),
                        OUTPUT_W, SIGN_EXT != 0));
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        rd_left_d  = rd_left_q;
        ph_d       = ph_q;
        b_d        = b_q;
        bcnt_d     = bcnt_q;
        wr_cnt_d   = wr_cnt_q;
        cap_d      = cap_q;
        rr_d       = rr_q;
        err_d      = err_q;
        done_d     = 1'b0;
        mem_en_d   = 1'b0;
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        w_abort    = abort && (state_q != ST_IDLE);
        w_err_set  = fc_out_vld && (state_q != ST_WAIT);
        w_rd_first = 1'b0;
        w_rd_go    = 1'b0;
        w_wr_go    = 1'b0;
        w_rd_addr  = rd_ptr_q;

        if (rd_ack) rr_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (batch_cnt != '0 && batch_cnt <= BCW'(MAX_BATCH)) begin
                        state_d    = ST_LOAD;
                        err_d      = 1'b0;
                        rr_d       = 1'b0;
                        bcnt_d     = batch_cnt;
                        b_d        = '0;
                        wr_ptr_d   = STORE_BASE;
                        w_rd_addr  = LOAD_BASE;
                        w_rd_first = 1'b1;
                    end else begin
                        w_err_set = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                if (rd_left_q != '0) begin
                    if (ph_q == PW'(IPW - 1)) w_rd_go = 1'b1;
                    else                      ph_d    = ph_q + 1'b1;
                end
                if (fc_in_last) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (fc_out_vld) begin
                    cap_d   = fc_out_dat;
                    state_d = ST_STORE;
                    w_wr_go = 1'b1;
                end
            end
            ST_STORE: begin
                if (wr_cnt_q != WCW'(WPB_OUT)) begin
                    w_wr_go = 1'b1;
                end else begin
                    wr_cnt_d = '0;
                    if (b_q == bcnt_q - 1'b1) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        b_d        = b_q + 1'b1;
                        state_d    = ST_LOAD;
                        w_rd_first = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                rr_d    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (w_rd_first || w_rd_go) begin
            mem_en_d   = 1'b1;
            mem_addr_d = w_rd_addr;
            rd_ptr_d   = w_rd_addr + 1'b1;
            ph_d       = '0;
            rd_left_d  = w_rd_first ? RLW'(WPB_IN - 1) : rd_left_q - 1'b1;
        end
        if (w_wr_go) begin
            mem_en_d   = 1'b1;
            mem_we_d   = 1'b1;
            mem_addr_d = wr_ptr_q;
            mem_din_d  = w_pack_word;
            wr_ptr_d   = wr_ptr_q + 1'b1;
            wr_cnt_d   = wr_cnt_q + 1'b1;
        end

        if (w_err_set) err_d = 1'b1;

        if (w_abort) begin
            state_d  = ST_IDLE;
            mem_en_d = 1'b0;
            mem_we_d = 1'b0;
            done_d   = 1'b0;
            wr_cnt_d = '0;
            rr_d     = rd_ack ? 1'b0 : rr_q;
        end

        // A read issued last cycle returns data now; abort drops it on the floor.
        rd_pend_d = !w_abort && mem_en_q && !mem_we_q;
        busy_d    = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rd_ptr_q   <= LOAD_BASE;
            wr_ptr_q   <= STORE_BASE;
            rd_left_q  <= '0;
            ph_q       <= '0;
            rd_pend_q  <= 1'b0;
            b_q        <= '0;
            bcnt_q     <= '0;
            wr_cnt_q   <= '0;
            cap_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rr_q       <= 1'b0;
            err_q      <= 1'b0;
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
        end else begin
            state_q    <= state_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_left_q  <= rd_left_d;
            ph_q       <= ph_d;
            rd_pend_q  <= rd_pend_d;
            b_q        <= b_d;
            bcnt_q     <= bcnt_d;
            wr_cnt_q   <= wr_cnt_d;
            cap_q      <= cap_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rr_q       <= rr_d;
            err_q      <= err_d;
            mem_en_q   <= mem_en_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
        end
    end

    fc_in_unpacker #(
        .INPUT_W   (INPUT_W),
        .WORD_W    (WORD_W),
        .DIM_INPUT (DIM_INPUT)
    ) u_unpacker (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (w_abort),
        .load_i  (rd_pend_q),
        .word_i  (mem_dout),
        .vld_o   (fc_in_vld),
        .dat_o   (fc_in_dat),
        .last_o  (fc_in_last)
    );

    assign busy         = busy_q;
    assign done         = done_q;
    assign result_ready = rr_q;
    assign err          = err_q;
    assign mem_en       = mem_en_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_din      = mem_din_q;

endmodule
`default_nettype wire
